// File: rtl/popcount_arb_pkg.sv
// rtl/popcount_arb_pkg.sv - shared constants and state encoding for popcount_req_arbiter
package popcount_arb_pkg;

    localparam int          ARB_DW        = 32;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'd1023;
    localparam logic [31:0] ERR_MARKER    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_LO   = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_CAPTURE   = 3'd5
    } arb_state_t;

endpackage

// File: rtl/rr_pick_onehot.sv
// rtl/rr_pick_onehot.sv - combinational round-robin picker (one-hot grant plus index)
module rr_pick_onehot
    import popcount_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            k;
    logic [IW-1:0] kidx;

    // Scan ptr, ptr+1, ... wrapping at N; the first set request wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        k    = 0;
        kidx = '0;
        for (int i = 0; i < N; i++) begin
            k    = (int'(ptr) + i) % N;
            kidx = IW'(k);
            if (!any && req[kidx]) begin
                any       = 1'b1;
                gnt[kidx] = 1'b1;
                idx       = kidx;
            end
        end
    end

endmodule

// File: rtl/popcount_req_arbiter.sv
// rtl/popcount_req_arbiter.sv - round-robin sequencer sharing one popcount engine; watchdog under POPCNT_ARB_TIMEOUT_EN
module popcount_req_arbiter
    import popcount_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int START_HOLD = 2,
    parameter int DW         = ARB_DW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_req,
    input  logic [N*DW-1:0] i_data,
    output logic [N-1:0]    o_gnt,
    output logic [N-1:0]    o_res_valid,
    output logic [DW-1:0]   o_res_data,
    output logic            o_busy,
    output logic            o_eng_start,
    output logic [DW-1:0]   o_eng_data,
`ifdef POPCNT_ARB_TIMEOUT_EN
    output logic            o_timeout,
`endif
    input  logic            i_eng_done,
    input  logic [DW-1:0]   i_eng_data
);

    localparam int            IW        = $clog2(N);
    localparam int            HW        = $clog2(START_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    logic [HW-1:0] hold_cnt;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          wd_fire;

    rr_pick_onehot #(.N(N), .IW(IW)) u_pick (
        .req (i_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef POPCNT_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // A done arriving on the limit cycle still wins over the forced error capture.
    assign wd_fire = (wd_cnt == TIMEOUT_LIMIT) &&
                     ((state == ST_WAIT_LO) || (state == ST_WAIT_DONE && !i_eng_done));

    // Watchdog: count cycles spent waiting on the engine, restart outside the wait states.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (state == ST_WAIT_LO || state == ST_WAIT_DONE) begin
                wd_cnt <= wd_cnt + 16'd1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_fire) begin
                o_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; stale done is rejected by passing through WAIT_LO.
    always_comb begin
        state_nxt   = state;
        o_busy      = (state != ST_IDLE);
        o_eng_start = 1'b0;
        o_res_valid = '0;
        case (state)
            ST_IDLE:      if (pick_any) state_nxt = ST_LATCH;
            ST_LATCH:     state_nxt = ST_START;
            ST_START: begin
                o_eng_start = 1'b1;
                if (hold_cnt == HOLD_LAST) state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO:   if (!i_eng_done) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i_eng_done) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                o_res_valid = o_gnt;
                state_nxt   = ST_IDLE;
            end
            default:      state_nxt = ST_IDLE;
        endcase
        if (wd_fire) state_nxt = ST_CAPTURE;
    end

    // Datapath: winner/grant, operand latch, start-hold count, result capture, pointer advance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr     <= '0;
            win_idx    <= '0;
            o_gnt      <= '0;
            o_res_data <= '0;
            o_eng_data <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        win_idx <= pick_idx;
                        o_gnt   <= pick_gnt;
                    end
                end
                ST_LATCH: begin
                    o_eng_data <= i_data[int'(win_idx)*DW +: DW];
                    hold_cnt   <= '0;
                end
                ST_START:     hold_cnt <= hold_cnt + 1'b1;
                ST_WAIT_DONE: if (i_eng_done) o_res_data <= i_eng_data;
                ST_CAPTURE: begin
                    o_gnt  <= '0;
                    rr_ptr <= (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
                end
                default: ;
            endcase
            if (wd_fire) o_res_data <= ERR_MARKER;
        end
    end

endmodule

// File: tb/tb_popcount_req_arbiter.sv
// tb/tb_popcount_req_arbiter.sv - randomized self-checking bench with behavioural arbiter and engine models
module tb_popcount_req_arbiter;

    localparam int          N          = 4;
    localparam int          DW         = 32;
    localparam int          START_HOLD = 2;
    localparam int          BUDGET     = 1200;
    localparam logic [31:0] GARB       = 32'hA5C3_0F96;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_res_valid;
    logic [DW-1:0]   o_res_data;
    logic            o_busy;
    logic            o_eng_start;
    logic [DW-1:0]   o_eng_data;
    logic            i_eng_done;
    logic [DW-1:0]   i_eng_data;
`ifdef POPCNT_ARB_TIMEOUT_EN
    logic            o_timeout;
`endif

    always #5 i_clk = ~i_clk;

    popcount_req_arbiter #(.N(N), .START_HOLD(START_HOLD), .DW(DW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_data      (i_data),
        .o_gnt       (o_gnt),
        .o_res_valid (o_res_valid),
        .o_res_data  (o_res_data),
        .o_busy      (o_busy),
        .o_eng_start (o_eng_start),
        .o_eng_data  (o_eng_data),
`ifdef POPCNT_ARB_TIMEOUT_EN
        .o_timeout   (o_timeout),
`endif
        .i_eng_done  (i_eng_done),
        .i_eng_data  (i_eng_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // Per-requester operand FIFOs feeding the request fabric.
    logic [31:0]  ops [N][256];
    int           op_wr [N];
    int           op_rd [N];
    logic [N-1:0] pending;
    logic [N-1:0] drop_mode;
    bit           eng_stall;

    task automatic push(input int k, input logic [31:0] v);
        ops[k][op_wr[k] % 256] = v;
        op_wr[k]++;
    endtask

    function automatic bit queues_empty();
        for (int k = 0; k < N; k++) if (op_wr[k] != op_rd[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Engine model: done stays up (with old result) for a few cycles after a new start.
    int          e_ph, e_drop, e_lat;
    logic [31:0] e_op;
    initial begin
        i_eng_done = 1'b0;
        i_eng_data = GARB;
        e_ph = 0; e_drop = 0; e_lat = 0; e_op = '0;
        forever begin
            @(negedge i_clk or posedge i_rst);
            if (i_rst) begin
                i_eng_done = 1'b0;
                i_eng_data = GARB;
                e_ph = 0;
            end else begin
                case (e_ph)
                    0: if (o_eng_start) begin
                        e_op   = o_eng_data;
                        e_drop = $urandom_range(0, 3);
                        e_ph   = 1;
                    end
                    1: begin
                        if (e_drop == 0) begin
                            i_eng_done = 1'b0;
                            i_eng_data = GARB;
                            if (!o_eng_start) begin
                                e_lat = $urandom_range(1, 6);
                                e_ph  = 2;
                            end
                        end else begin
                            e_drop--;
                        end
                    end
                    default: if (!eng_stall) begin
                        if (e_lat == 0) begin
                            i_eng_done = 1'b1;
                            i_eng_data = 32'($countones(e_op));
                            e_ph = 0;
                        end else begin
                            e_lat--;
                        end
                    end
                endcase
            end
        end
    end

    // Request fabric: hold request until own result, optionally drop after grant, scramble operand after latch.
    initial begin
        i_req = '0;
        i_data = '0;
        pending = '0;
        forever begin
            @(posedge i_clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (i_rst) begin
                    pending[k] = 1'b0;
                end else if (o_res_valid[k]) begin
                    if (op_wr[k] != op_rd[k]) op_rd[k]++;
                    pending[k] = 1'b0;
                end else if (o_gnt[k] && !pending[k]) begin
                    pending[k] = 1'b1;
                end else if (pending[k]) begin
                    i_data[k*DW +: DW] = $urandom;
                    i_req[k] = !drop_mode[k];
                end
                if (!pending[k]) begin
                    i_req[k] = (op_wr[k] != op_rd[k]);
                    i_data[k*DW +: DW] = i_req[k] ? ops[k][op_rd[k] % 256] : $urandom;
                end
            end
        end
    end

    // Behavioural arbiter model and the per-cycle compare.
    int           rrp, win, ph;
    bit           active, tmo_model;
    logic [31:0]  exp_op, exp_res, last_res;
    logic [N-1:0] req_prev;
    int           log_win[$];
    logic [31:0]  log_res[$];
    initial begin
        rrp = 0; win = 0; ph = 0; active = 0; tmo_model = 0;
        exp_op = '0; exp_res = '0; last_res = '0; req_prev = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                check("reset_outs", {o_gnt, o_res_valid, o_res_data, o_busy, o_eng_start, o_eng_data}, '0);
                rrp = 0; active = 0; last_res = '0; tmo_model = 0;
            end else begin
                check("busy_vs_gnt", o_busy, |o_gnt);
                if (!active) begin
                    if (o_gnt != '0) begin
                        win = first_req(req_prev, rrp);
                        check("grant", o_gnt, (win < 0) ? 0 : (1 << win));
                        if (win < 0) win = first_req(o_gnt, 0);
                        active  = 1;
                        ph      = 0;
                        exp_op  = i_data[win*DW +: DW];
                        exp_res = eng_stall ? 32'hFFFF_FFFF : 32'($countones(exp_op));
                    end
                    check("idle_valid", o_res_valid, '0);
                    check("idle_start", o_eng_start, 1'b0);
                end else begin
                    ph++;
                    check("gnt_hold", o_gnt, 1 << win);
                    check("eng_data", o_eng_data, exp_op);
                    check("eng_start", o_eng_start, (ph <= START_HOLD));
                    if (o_res_valid != '0) begin
                        check("valid_onehot", o_res_valid, 1 << win);
                        check("res_data", o_res_data, exp_res);
                        check("latency", (ph >= START_HOLD + 3), 1'b1);
                        log_win.push_back(win);
                        log_res.push_back(exp_res);
                        last_res = exp_res;
                        if (eng_stall) tmo_model = 1;
                        rrp    = (win + 1) % N;
                        active = 0;
                    end else if (ph > BUDGET) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL valid_wait: no result for requester %0d after %0d cycles", win, ph);
                        active = 0;
                    end
                end
                if (o_res_valid == '0) check("res_hold", o_res_data, last_res);
`ifdef POPCNT_ARB_TIMEOUT_EN
                check("timeout_flag", o_timeout, tmo_model);
`endif
            end
            req_prev = i_req;
        end
    end

    task automatic wait_idle(input int limit);
        int c = 0;
        while (c < limit) begin
            @(negedge i_clk);
            c++;
            if (queues_empty() && !o_busy && !active && pending == '0) break;
        end
        n_cmp++;
        if (c >= limit) begin
            n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", limit);
        end
    endtask

    task automatic check_log(input int i, input int exp_w, input logic [31:0] exp_r);
        check("log_size", (log_win.size() > i), 1'b1);
        if (log_win.size() > i) begin
            check("log_winner", log_win[i], exp_w);
            check("log_result", log_res[i], exp_r);
        end
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int pushed;
        int k;
        logic [31:0] t2_ops [4];
        logic [31:0] t2_res [4];
        t2_ops = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0001};
        t2_res = '{32'd0, 32'd32, 32'd1, 32'd2};
        eng_stall = 0;
        drop_mode = '0;
        for (int j = 0; j < N; j++) begin op_wr[j] = 0; op_rd[j] = 0; end

        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_state", {o_gnt, o_res_valid, o_res_data, o_busy, o_eng_start, o_eng_data}, '0);
        i_rst = 1'b0;

        // Single request from requester 0.
        log_win.delete(); log_res.delete();
        push(0, 32'h0000_00F3);
        wait_idle(200);
        check_log(0, 0, 32'd6);

        // All four requests present at reset release: lowest index first.
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        for (int j = 0; j < N; j++) push(j, t2_ops[j]);
        log_win.delete(); log_res.delete();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        wait_idle(400);
        for (int j = 0; j < N; j++) check_log(j, j, t2_res[j]);

        // Requester 1 continuous, requester 2 joins mid-operation: alternation.
        log_win.delete(); log_res.delete();
        push(1, 32'h3); push(1, 32'hF);
        repeat (3) @(posedge i_clk);
        #1;
        push(2, 32'h7); push(2, 32'h1F);
        wait_idle(600);
        check_log(0, 1, 32'd2);
        check_log(1, 2, 32'd3);
        check_log(2, 1, 32'd4);
        check_log(3, 2, 32'd5);

        // Requester 2 drops its request right after grant; the result still arrives.
        log_win.delete(); log_res.delete();
        drop_mode[2] = 1'b1;
        push(2, 32'h0F0F_0F0F);
        repeat (2) @(posedge i_clk);
        #1;
        push(0, 32'h3);
        wait_idle(400);
        check_log(0, 2, 32'd16);
        check_log(1, 0, 32'd2);
        drop_mode = '0;

        // Reset while waiting on a stalled engine, then a fresh request.
        eng_stall = 1;
        push(1, 32'hFF);
        for (int c = 0; c < 100 && !(active && ph >= START_HOLD + 4); c++) @(negedge i_clk);
        check("reached_wait_done", (active && ph >= START_HOLD + 4), 1'b1);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_reset", {o_gnt, o_res_valid, o_res_data, o_busy, o_eng_start, o_eng_data}, '0);
        for (int j = 0; j < N; j++) op_rd[j] = op_wr[j];
        eng_stall = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        log_win.delete(); log_res.delete();
        push(3, 32'h7);
        wait_idle(200);
        check_log(0, 3, 32'd3);

`ifdef POPCNT_ARB_TIMEOUT_EN
        // Engine never completes: error marker, sticky timeout until reset.
        log_win.delete(); log_res.delete();
        eng_stall = 1;
        push(0, 32'h1234_5678);
        wait_idle(1500);
        check_log(0, 0, 32'hFFFF_FFFF);
        repeat (20) @(posedge i_clk);
        #1;
        check("timeout_sticky", o_timeout, 1'b1);
        i_rst = 1'b1;
        #1;
        check("timeout_cleared", o_timeout, 1'b0);
        eng_stall = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
`endif

        // Randomized traffic.
        log_win.delete(); log_res.delete();
        pushed = 0;
        for (int it = 0; it < 200; it++) begin
            k = $urandom_range(0, N - 1);
            if (op_wr[k] - op_rd[k] < 4) begin
                push(k, rand_op());
                pushed++;
            end
            drop_mode[k] = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 12)) @(posedge i_clk);
            #1;
        end
        wait_idle(5000);
        check("random_count", log_win.size(), pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
